// File: rtl/volume_gain_stage_if.sv
// Sample stream bundle for the volume stage: upstream input plus downstream output handshake.
// Pure wiring: no latency of its own.
// Backpressure is carried by in_ready (to the upstream) and out_ready (from the downstream).
interface volume_gain_stage_if #(
    parameter int SAMPLE_W = 24
);
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic signed [SAMPLE_W-1:0] out_data;
    logic                       out_ready;

    // Source/sink side: drives samples in and accepts results out
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Gain stage side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/volume_gain_stage.sv
// Volume stage: decodes a thermometer volume code, ramps the gain one level per step, scales samples by level/8.
// Latency: 2 cycles from acceptance to out_valid, 1 sample/cycle when not stalled.
// Backpressure: out_valid & ~out_ready freezes both stages and drops in_ready. Optional macro ZERO_CROSS_EN.
module volume_gain_stage #(
    parameter int SAMPLE_W = 24,
    parameter int RAMP_DIV = 64
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [7:0]          Vol_code,
    volume_gain_stage_if.slave  bus,
    output logic [3:0]          gain_lvl,
    output logic                vol_err
);
    localparam int CNT_W = $clog2(RAMP_DIV);

    // Reset synchroniser outputs
    logic [1:0]                 rst_sync;
    logic                       rst_n;

    // Volume decode
    logic                       code_legal;
    logic [3:0]                 code_lvl;
    logic [3:0]                 target;

    // Handshake
    logic                       stall;
    logic                       accept;

    // Ramp control
    logic [CNT_W-1:0]           ramp_cnt;
    logic                       ramp_wrap;
    logic                       pending;
    logic                       step;
    logic [3:0]                 lvl_next;

    // Pipeline
    logic                       s1_vld;
    logic signed [SAMPLE_W-1:0] s1_dat;
    logic [3:0]                 s1_lvl;
    logic signed [SAMPLE_W+4:0] dat_x;
    logic signed [SAMPLE_W+4:0] lvl_x;
    logic signed [SAMPLE_W+4:0] prod;
    logic                       out_vld;
    logic signed [SAMPLE_W-1:0] out_dat;

    // Reset asserts immediately, releases two clock edges later so every flop leaves reset in the same cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Map legal thermometer codes to a level; anything with a hole in it is flagged
    always_comb begin
        code_legal = 1'b1;
        code_lvl   = 4'd0;
        case (Vol_code)
            8'h00:   code_lvl = 4'd0;
            8'h01:   code_lvl = 4'd1;
            8'h03:   code_lvl = 4'd2;
            8'h07:   code_lvl = 4'd3;
            8'h0f:   code_lvl = 4'd4;
            8'h1f:   code_lvl = 4'd5;
            8'h3f:   code_lvl = 4'd6;
            8'h7f:   code_lvl = 4'd7;
            8'hff:   code_lvl = 4'd8;
            default: code_legal = 1'b0;
        endcase
    end

    // Target follows the code every cycle; a malformed code keeps the last good target and latches the error
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            target  <= 4'd0;
            vol_err <= 1'b0;
        end else begin
            if (code_legal) begin
                target <= code_lvl;
            end else begin
                vol_err <= 1'b1;
            end
        end
    end

    // A full output register whose consumer is not ready blocks the whole pipe
    assign stall         = out_vld & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign accept        = bus.in_valid & ~stall;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_dat;

    // The ramp clock is the accepted-sample count, so the gain never moves while the stream is idle
    assign ramp_wrap = accept & (ramp_cnt == CNT_W'(RAMP_DIV - 1));
    assign pending   = (gain_lvl != target);

    // Free-running modulo-RAMP_DIV count of accepted samples
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt <= '0;
        end else if (accept) begin
            ramp_cnt <= ramp_wrap ? '0 : ramp_cnt + CNT_W'(1);
        end
    end

`ifdef ZERO_CROSS_EN
    localparam int WAIT_LIM = 4 * RAMP_DIV;
    localparam int WAIT_W   = $clog2(WAIT_LIM);

    logic [WAIT_W-1:0] wait_cnt;
    logic              armed;
    logic              prev_neg;
    logic              zero_cross;
    logic              force_step;

    // A crossing is an exact zero or a sign flip against the previous accepted sample
    assign zero_cross = (bus.in_data == '0) || (bus.in_data[SAMPLE_W-1] != prev_neg);
    // Give up waiting for a crossing on the 4*RAMP_DIV-th pending sample so a DC input still ramps
    assign force_step = (wait_cnt == WAIT_W'(WAIT_LIM - 1));
    // A wrap arms the step; the armed step fires on the next crossing, one level per crossing
    assign step = accept & pending & (((armed | ramp_wrap) & zero_cross) | force_step);

    // Zero-crossing bookkeeping: previous sign, arming by wrap, and the force timeout
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            armed    <= 1'b0;
            prev_neg <= 1'b0;
        end else begin
            if (accept) begin
                prev_neg <= bus.in_data[SAMPLE_W-1];
            end
            if (step) begin
                armed <= 1'b0;
            end else if (ramp_wrap) begin
                armed <= 1'b1;
            end
            if (step || !pending) begin
                wait_cnt <= '0;
            end else if (accept) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end
`else
    // Without zero-crossing alignment, every wrap with a pending difference takes one step
    assign step = ramp_wrap & pending;
`endif

    // One level toward the target; direction is re-read at every step so a moving target never overshoots
    always_comb begin
        lvl_next = gain_lvl;
        if (step) begin
            lvl_next = (target > gain_lvl) ? gain_lvl + 4'd1 : gain_lvl - 4'd1;
        end
    end

    // Applied level register; starts at silence so the output fades in after reset
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_lvl <= 4'd0;
        end else begin
            gain_lvl <= lvl_next;
        end
    end

    // Stage 1: capture the sample with the level it must use (the new level on a step beat)
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_lvl <= 4'd0;
        end else if (!stall) begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= bus.in_data;
                s1_lvl <= lvl_next;
            end
        end
    end

    // Full-width signed product; level is zero-extended so 8 stays positive
    assign dat_x = (SAMPLE_W + 5)'(s1_dat);
    assign lvl_x = (SAMPLE_W + 5)'({1'b0, s1_lvl});
    assign prod  = dat_x * lvl_x;

    // Stage 2: divide by 8 with an arithmetic shift (floor); |level/8| <= 1 so no saturation is needed
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (!stall) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_dat <= SAMPLE_W'(prod >>> 3);
            end
        end
    end

endmodule

// File: tb/tb_volume_gain_stage.sv
// Self-checking bench for volume_gain_stage against an arithmetic reference model.
// Each accepted sample is scored as floor(in*level/8) with the level from the ramp rules.
// Randomised data, valid and ready; stalls and reset mid-stream are exercised.
module tb_volume_gain_stage;
    localparam int SAMPLE_W = 24;
    localparam int RAMP_DIV = 64;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Vol_code = 8'hff;
    logic [3:0] gain_lvl;
    logic       vol_err;

    volume_gain_stage_if #(.SAMPLE_W(SAMPLE_W)) bus ();

    volume_gain_stage #(
        .SAMPLE_W(SAMPLE_W),
        .RAMP_DIV(RAMP_DIV)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Vol_code(Vol_code),
        .bus     (bus),
        .gain_lvl(gain_lvl),
        .vol_err (vol_err)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int     m_lvl;
    int     m_tgt;
    int     m_nacc;
    bit     m_err;
    bit     m_armed;
    bit     m_prev_neg;
    int     m_wait;
    longint exp_q[$];

    // Per-step observations
    bit                         acc;
    bit                         rdy_seen;
    bit                         ov_seen;
    bit                         have_out;
    logic signed [SAMPLE_W-1:0] got_out;
    longint                     exp_out;
    logic [3:0]                 lvl_now;

    function automatic longint floor_div8(input longint p);
        if (p >= 0) return p / 8;
        return -((-p + 7) / 8);
    endfunction

    function automatic bit is_thermo(input logic [7:0] c);
        logic [8:0] m;
        m = (9'd1 << $countones(c)) - 9'd1;
        return c == m[7:0];
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, (1 << SAMPLE_W) - 1)) - (1 << (SAMPLE_W - 1));
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_nacc = 0; m_err = 0; m_armed = 0; m_prev_neg = 0; m_wait = 0;
        m_tgt = is_thermo(Vol_code) ? $countones(Vol_code) : 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int d);
        bit wrap;
        int dir;
        m_nacc++;
        wrap = (m_nacc % RAMP_DIV) == 0;
        dir  = (m_tgt > m_lvl) ? 1 : -1;
`ifdef ZERO_CROSS_EN
        begin
            bit neg, zc;
            neg = d < 0;
            zc  = (d == 0) || (neg != m_prev_neg);
            m_prev_neg = neg;
            if (wrap) m_armed = 1;
            if (m_lvl != m_tgt) begin
                m_wait++;
                if ((m_armed && zc) || m_wait == 4 * RAMP_DIV) begin
                    m_lvl += dir; m_armed = 0; m_wait = 0;
                end
            end else begin
                m_wait = 0;
            end
        end
`else
        if (wrap && m_lvl != m_tgt) m_lvl += dir;
`endif
        exp_q.push_back(floor_div8(longint'(d) * m_lvl));
    endtask

    // One clock: drive, observe at the falling edge, advance the model, read the level after the edge
    task automatic step(input bit v, input int d, input bit r);
        bus.in_valid  = v;
        bus.in_data   = SAMPLE_W'(d);
        bus.out_ready = r;
        @(negedge Clk);
        acc      = bus.in_valid && bus.in_ready;
        rdy_seen = bus.in_ready;
        ov_seen  = bus.out_valid;
        have_out = bus.out_valid && bus.out_ready;
        got_out  = bus.out_data;
        if (have_out) exp_out = (exp_q.size() != 0) ? exp_q.pop_front() : 64'sh7fff_ffff_ffff_ffff;
        if (acc) model_accept(d);
        @(posedge Clk);
        #1;
        lvl_now = gain_lvl;
    endtask

    task automatic set_vol(input logic [7:0] code);
        Vol_code = code;
        if (is_thermo(code)) m_tgt = $countones(code);
        else m_err = 1;
        step(0, 0, 1);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1; Vol_code = 8'hff;
        Reset = 1;
        #2 Reset = 0;
        repeat (3) @(negedge Clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
        tests++; if (gain_lvl !== 4'd0) begin fails++; $display("FAIL reset_gain_lvl: got %0d expected 0", gain_lvl); end
        tests++; if (vol_err !== 1'b0) begin fails++; $display("FAIL reset_vol_err: got %b expected 0", vol_err); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge Clk); #1;
        Reset = 1;
        model_reset();
        repeat (4) step(0, 0, 1);
    endtask

    task automatic test_ramp_up();
        for (int i = 0; i < 8 * RAMP_DIV + 4; i++) begin
            step(1, 1000, 1);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL ramp_out[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
            tests++;
            if (lvl_now !== 4'(m_lvl)) begin fails++; $display("FAIL ramp_lvl[%0d]: got %0d expected %0d", i, lvl_now, m_lvl); end
`ifndef ZERO_CROSS_EN
            if (i == 2) begin
                tests++;
                if (got_out !== 0) begin fails++; $display("FAIL ramp_first_out: got %0d expected 0", got_out); end
            end
            if (i == 8 * RAMP_DIV - 2) begin
                tests++;
                if (lvl_now !== 4'd7) begin fails++; $display("FAIL ramp_lvl_before_last: got %0d expected 7", lvl_now); end
            end
            if (i == 8 * RAMP_DIV - 1) begin
                tests++;
                if (lvl_now !== 4'd8) begin fails++; $display("FAIL ramp_lvl_full: got %0d expected 8", lvl_now); end
            end
            if (i == 8 * RAMP_DIV + 3) begin
                tests++;
                if (got_out !== 1000) begin fails++; $display("FAIL ramp_last_out: got %0d expected 1000", got_out); end
            end
`endif
        end
    endtask

    task automatic test_passthrough();
        int vals[2];
        vals[0] = -3; vals[1] = -12345;
        repeat (3) step(0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step(1, vals[k], 1);
            step(0, 0, 1);
            tests++;
            if (ov_seen !== 1'b0) begin fails++; $display("FAIL pass_early_valid[%0d]: got %b expected 0", k, ov_seen); end
            step(0, 0, 1);
            tests++;
            if (!ov_seen || got_out !== vals[k]) begin
                fails++; $display("FAIL pass_out[%0d]: got valid %b data %0d expected valid 1 data %0d", k, ov_seen, got_out, vals[k]);
            end
        end
    endtask

    task automatic test_level3();
        int d;
        set_vol(8'h07);
        for (int i = 0; i < 5 * RAMP_DIV + 4; i++) begin
            d = rnd_sample();
            step(1, d, 1);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL lvl3_out[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
            tests++;
            if (lvl_now !== 4'(m_lvl)) begin fails++; $display("FAIL lvl3_lvl[%0d]: got %0d expected %0d", i, lvl_now, m_lvl); end
        end
        step(1, -1, 1);
        step(1, 7, 1);
        step(0, 0, 1);
        tests++;
        if (got_out !== exp_out) begin fails++; $display("FAIL lvl3_neg1_model: got %0d expected %0d", got_out, exp_out); end
`ifndef ZERO_CROSS_EN
        tests++;
        if (got_out !== -1) begin fails++; $display("FAIL lvl3_neg1: got %0d expected -1", got_out); end
`endif
        step(0, 0, 1);
        tests++;
        if (got_out !== exp_out) begin fails++; $display("FAIL lvl3_pos7_model: got %0d expected %0d", got_out, exp_out); end
`ifndef ZERO_CROSS_EN
        tests++;
        if (got_out !== 2) begin fails++; $display("FAIL lvl3_pos7: got %0d expected 2", got_out); end
`endif
    endtask

    task automatic test_stall();
        logic signed [SAMPLE_W-1:0] held;
        bit r;
        held = '0;
        for (int i = 0; i < 30; i++) begin
            r = !(i >= 8 && i < 13);
            step(1, rnd_sample(), r);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL stall_out[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
            if (i == 8) held = got_out;
            if (i >= 8 && i < 13) begin
                tests++;
                if (rdy_seen !== 1'b0 || got_out !== held) begin
                    fails++; $display("FAIL stall_hold[%0d]: got ready %b data %0d expected ready 0 data %0d", i, rdy_seen, got_out, held);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL stall_drain[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL stall_lost: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic run_stream(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step(1, rnd_sample(), 1);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL %s_out[%0d]: got %0d expected %0d", name, i, got_out, exp_out); end
            end
            tests++;
            if (lvl_now !== 4'(m_lvl)) begin fails++; $display("FAIL %s_lvl[%0d]: got %0d expected %0d", name, i, lvl_now, m_lvl); end
        end
    endtask

    task automatic test_vol_err();
        set_vol(8'h0f);
        run_stream("err_up", RAMP_DIV + 2);
`ifndef ZERO_CROSS_EN
        tests++;
        if (lvl_now !== 4'd4) begin fails++; $display("FAIL err_lvl4: got %0d expected 4", lvl_now); end
`endif
        set_vol(8'h05);
        tests++;
        if (vol_err !== 1'b1) begin fails++; $display("FAIL err_flag_set: got %b expected 1", vol_err); end
        run_stream("err_hold", 2 * RAMP_DIV);
        set_vol(8'h01);
        run_stream("err_down", 3 * RAMP_DIV + 2);
`ifndef ZERO_CROSS_EN
        tests++;
        if (lvl_now !== 4'd1) begin fails++; $display("FAIL err_lvl1: got %0d expected 1", lvl_now); end
`endif
        tests++;
        if (vol_err !== m_err) begin fails++; $display("FAIL err_flag_sticky: got %b expected %b", vol_err, m_err); end
    endtask

    task automatic test_random();
        int d;
        bit v, r;
        for (int i = 0; i < 1200; i++) begin
            if (i % 200 == 199) set_vol(8'((1 << $urandom_range(0, 8)) - 1));
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 15) == 0) ? 0 : rnd_sample();
            step(v, d, r);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL rand_out[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
            tests++;
            if (lvl_now !== 4'(m_lvl)) begin fails++; $display("FAIL rand_lvl[%0d]: got %0d expected %0d", i, lvl_now, m_lvl); end
        end
    endtask

    task automatic test_reset_midstream();
        step(1, 4000, 1);
        step(1, -4000, 1);
        Reset = 0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL mid_out_data: got %0d expected 0", bus.out_data); end
        tests++; if (gain_lvl !== 4'd0) begin fails++; $display("FAIL mid_gain_lvl: got %0d expected 0", gain_lvl); end
        tests++; if (vol_err !== 1'b0) begin fails++; $display("FAIL mid_vol_err: got %b expected 0", vol_err); end
        Vol_code = 8'hff;
        @(posedge Clk); #1;
        Reset = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            tests++;
            if (ov_seen !== 1'b0) begin fails++; $display("FAIL mid_replay[%0d]: got valid %b expected 0", i, ov_seen); end
        end
    endtask

`ifdef ZERO_CROSS_EN
    task automatic test_zero_cross();
        int n;
        n = 0;
        while (m_lvl != 8 && n < 12 * RAMP_DIV) begin
            step(1, (n % 2 == 0) ? 500 : -500, 1);
            n++;
        end
        tests++;
        if (lvl_now !== 4'd8) begin fails++; $display("FAIL zc_reach8: got %0d expected 8", lvl_now); end
        repeat (4) step(1, 500, 1);
        set_vol(8'h00);
        for (int i = 1; i <= 4 * RAMP_DIV; i++) begin
            step(1, 500, 1);
            if (have_out) begin
                tests++;
                if (got_out !== exp_out) begin fails++; $display("FAIL zc_out[%0d]: got %0d expected %0d", i, got_out, exp_out); end
            end
            if (i == 4 * RAMP_DIV - 1) begin
                tests++;
                if (lvl_now !== 4'd8) begin fails++; $display("FAIL zc_early_step: got %0d expected 8", lvl_now); end
            end
            if (i == 4 * RAMP_DIV) begin
                tests++;
                if (lvl_now !== 4'd7) begin fails++; $display("FAIL zc_forced_step: got %0d expected 7", lvl_now); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_up();
        test_passthrough();
        test_level3();
        test_stall();
        test_vol_err();
        test_random();
        test_reset_midstream();
`ifdef ZERO_CROSS_EN
        test_zero_cross();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
